seq_divider_64by32: RTL and testbench

//   Multi-cycle restoring divider. Divides a 64-bit product by a 32-bit divisor.
//   It is the inverse of the 32x32 Vedic multiplier: feeding it (a*b, b) returns quotient a, remainder 0.

---
 rtl/seq_divider_64by32_if.sv | 26 ++
 rtl/seq_divider_64by32.sv | 101 ++++++++++
 tb/tb_seq_divider_64by32.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_64by32_if.sv
// Valid/ready bundle for the 64-by-32 restoring divider.
// master = requester/consumer side, slave = divider side.
interface seq_divider_64by32_if #(
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_64by32.sv
// Restoring divider, one quotient bit per clock.
// Inverse of the 32x32 multiplier: (a*b, b) -> (a, 0).
module seq_divider_64by32 #(
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 32
) (
    input logic               clk,
    input logic               rst,
    seq_divider_64by32_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_d;
    logic [DIVISOR_W-1:0]  r_r;
    logic [CW-1:0]         r_cnt;
    logic                  r_zero;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dz;

    logic                  w_accept;
    logic [DIVISOR_W:0]    w_t;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;
    logic [DIVISOR_W-1:0]  w_r_nxt;
    logic [DIVIDEND_W-1:0] w_q_nxt;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    // Partial remainder stays below D, so its top bit is implicitly 0.
    assign w_t     = {r_r, r_q[DIVIDEND_W-1]};
    assign w_ge    = (w_t >= {1'b0, r_d});
    assign w_diff  = w_t[DIVISOR_W-1:0] - r_d;
    assign w_r_nxt = w_ge ? w_diff : w_t[DIVISOR_W-1:0];
    assign w_q_nxt = {r_q[DIVIDEND_W-2:0], w_ge};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_BUSY;
            S_BUSY: if (r_zero || (r_cnt == '0)) w_next = S_DONE;
            S_DONE: if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_q    <= bus.dividend;
            r_d    <= bus.divisor;
            r_r    <= '0;
            r_cnt  <= CW'(DIVIDEND_W - 1);
            r_zero <= (bus.divisor == '0);
        end else if (r_state == S_BUSY) begin
            // Zero divisor spends one BUSY cycle and skips the iterations.
            if (r_zero) begin
                r_quot <= '1;
                r_rem  <= r_q[DIVISOR_W-1:0];
                r_dz   <= 1'b1;
            end else begin
                r_q   <= w_q_nxt;
                r_r   <= w_r_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_quot <= w_q_nxt;
                    r_rem  <= w_r_nxt;
                    r_dz   <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_seq_divider_64by32.sv
// Directed and random checks of seq_divider_64by32 against
// a plain-arithmetic division model.
module tb_seq_divider_64by32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_divider_64by32_if bus ();

    seq_divider_64by32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [63:0] dvd, input logic [31:0] dvs);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = $urandom;
    endtask

    task automatic finish_chk(input string tag, input logic [63:0] dvd,
                              input logic [31:0] dvs);
        int          lat;
        logic [63:0] eq;
        logic [31:0] er;
        logic        ez;
        int          elat;
        if (dvs == 0) begin
            eq   = '1;
            er   = dvd[31:0];
            ez   = 1'b1;
            elat = 1;
        end else begin
            eq   = dvd / 64'(dvs);
            er   = 32'(dvd % 64'(dvs));
            ez   = 1'b0;
            elat = 64;
        end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < 200);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, 64'(bus.remainder), 64'(er));
        chk({tag, "_dz"}, 64'(bus.div_by_zero), 64'(ez));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic op(input string tag, input logic [63:0] dvd,
                      input logic [31:0] dvs);
        start(dvd, dvs);
        finish_chk(tag, dvd, dvs);
        release_out(tag);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] d;
        logic [63:0] hq;
        logic [31:0] hr;
        logic        hz;
        int          seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", 64'(bus.out_valid), 64'd0);
        chk("rst_q", bus.quotient, 64'd0);
        chk("rst_r", 64'(bus.remainder), 64'd0);
        chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);

        op("d100_7", 64'd100, 32'd7);
        op("max_max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
        op("max_1", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1);

        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            if (b == 0) b = 32'd1;
            d = 64'(a) * 64'(b);
            start(d, b);
            finish_chk("rt", d, b);
            chk("rt_a", bus.quotient, 64'(a));
            release_out("rt");
        end

        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd3;
            op("rnd", d, b);
        end

        op("dz", 64'h1234_5678_9ABC_DEF0, 32'd0);

        // Backpressure with a competing request held on the input.
        start(64'd1000, 32'd33);
        finish_chk("bp", 64'd1000, 32'd33);
        hq = bus.quotient;
        hr = bus.remainder;
        hz = bus.div_by_zero;
        bus.in_valid = 1'b1;
        bus.dividend = 64'd500;
        bus.divisor  = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ov", 64'(bus.out_valid), 64'd1);
            chk("bp_rdy", 64'(bus.in_ready), 64'd0);
            chk("bp_q", bus.quotient, hq);
            chk("bp_r", 64'(bus.remainder), 64'(hr));
            chk("bp_dz", 64'(bus.div_by_zero), 64'(hz));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ov_drop", 64'(bus.out_valid), 64'd0);
        chk("bp_rdy_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = '1;
        bus.divisor  = 32'd1;
        finish_chk("bp2", 64'd500, 32'd9);
        release_out("bp2");

        // Reset mid-division discards the operation.
        start(64'hDEAD_BEEF_0000_1234, 32'd77);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_q", bus.quotient, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_stale", 64'(seen), 64'd0);
        op("post_rst", 64'd100, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
